exec_core_p: RTL and testbench
==============================

EXEC_CORE_P -- requirements
Module: exec_core_p

Interface
REQ-001 Parameter DataSize, default 32, datapath and register width; legal values 32 and 64.
REQ-002 Parameter RegCount, default 32, number of architectural registers; legal range 2..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instruction  input  32  instruction word; sampled only on accept.
REQ-006 instr_valid  input  1  instruction word present.
REQ-007 instr_ready  output  1  core can accept an instruction.
REQ-008 done  output  1  one-cycle pulse: instruction retired.
REQ-009 illegal  output  1  one-cycle pulse: instruction rejected, no write.
REQ-010 dbg_addr  input  5  register index for readback.
REQ-011 dbg_data  output  DataSize  combinational read of register dbg_addr; 0 if dbg_addr >= RegCount.

Function
REQ-012 Field map SHALL be: bit31 = 0; op = [30:25]; rt = [24:20]; ra = [19:15]; rb/imm5 = [14:10]; sub = [4:0]; imm15 = [14:0]; imm20 = [19:0].
REQ-013 op 101000 ADDI: rt = ra + sign-extended imm15.
REQ-014 op 100010 MOVI: rt = sign-extended imm20.
REQ-015 op 101100 ORI and 101011 XORI: rt = ra OR/XOR zero-extended imm15.
REQ-016 op 100000 with sub 00000 ADD, 00001 SUB (ra-rb), 00010 AND, 00100 OR, 00011 XOR: rt = ra op rb.
REQ-017 op 100000 with sub 01000 SLLI, 01001 SRLI, 01010 SRAI, 01011 ROTRI: rt = ra shifted/rotated by imm5; logical fill zero, SRAI fills sign bit.
REQ-018 Arithmetic SHALL wrap modulo 2^DataSize, with no carry or overflow reported.
REQ-019 FSM states: IDLE, DECODE, EXECUTE, WRITEBACK; reset state IDLE.
REQ-020 IDLE: instr_ready = 1; instr_valid = 1 latches instruction, next state DECODE; otherwise stay.
REQ-021 DECODE: read ra/rb operands and immediate into pipeline registers; next state EXECUTE.
REQ-022 EXECUTE: compute result into a result register; next state WRITEBACK.
REQ-023 WRITEBACK: write rt, pulse done; next state IDLE.
REQ-024 Latency: exactly 4 cycles from accept edge to next possible accept; instr_ready = 0 in DECODE, EXECUTE and WRITEBACK.
REQ-025 Illegal instruction: bit31 = 1, unknown op/sub, or any used register index >= RegCount.
REQ-026 Illegal handling: detected in DECODE; no register write; illegal pulses in the WRITEBACK cycle instead of done; timing unchanged.
REQ-027 rt equal to ra or rb SHALL use the pre-write operand value.
REQ-028 instr_valid asserted while instr_ready = 0 SHALL be ignored; no queuing.
REQ-029 A dbg_addr equal to rt in the WRITEBACK cycle returns the old value; the new value is visible from the next cycle.

Reset
REQ-030 reset low SHALL immediately force: FSM to IDLE, all registers to 0, result/operand registers to 0, done = 0, illegal = 0, instr_ready = 1 after release.
REQ-031 reset asserted mid-instruction SHALL abort it with no register write and no done pulse.
REQ-032 The first accept SHALL occur on the first rising edge after reset deassertion with instr_valid = 1.

Verification
REQ-033 ADDI r0,r0,13; ADDI r1,r1,12; MOVI r2,16; ADD r3,r0,r1; SUB r4,r0,r1 -> r0=13, r1=12, r2=16, r3=25, r4=1; one done per instruction, 4 cycles apart.
REQ-034 Continue with AND r5,r3,r4; OR r6; XOR r7; SLLI r8,r0,4; ROTRI r9,r1,8 -> r5=1, r6=25, r7=24, r8=0xD0, r9=0x0C000000.
REQ-035 ORI r0,r0,0x1F; XORI r1,r1,0x15 -> r0=0x1F, r1=0x19. With r2=0x80000000 (MOVI -> sign-extended), SRAI r3,r2,4 -> 0xF8000000; SRLI -> 0x08000000.
REQ-036 Illegal cases: op 111111; RegCount=8 with rt=9; bit31=1 -> illegal pulse, no done, all registers unchanged, next instruction accepted 4 cycles later.
REQ-037 Reset asserted in EXECUTE of ADDI r5,r5,7 -> r5=0, no done; instr_valid held high during busy cycles -> only one accept per 4 cycles.
REQ-038 Sweep DataSize=64: ADDI r0,r0,-1 -> r0=0xFFFFFFFFFFFFFFFF; ROTRI r1,r0,8 keeps r1 all ones.

Source files
------------

// File: rtl/exec_core_p.sv
// exec_core_p: four-state multi-cycle integer execution core with a
// RegCount x DataSize register file and a combinational debug read port.
//
// Ports
//   clk          single clock, rising-edge state updates
//   reset        asynchronous active-low reset
//   instruction  32-bit instruction word, sampled on accept
//   instr_valid  instruction word present
//   instr_ready  high in IDLE: an instruction can be accepted
//   done         one-cycle pulse in WRITEBACK when a legal instruction retires
//   illegal      one-cycle pulse in WRITEBACK when an instruction is rejected
//   dbg_addr     register index for readback
//   dbg_data     contents of register dbg_addr, 0 when out of range
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready; an instruction is latched when instr_valid is high
// DECODE    | operands/immediate captured, legality decided
// EXECUTE   | ALU result captured into result_q
// WRITEBACK | rt written (legal only), done or illegal pulsed
module exec_core_p #(
    parameter int DataSize = 32,
    parameter int RegCount = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instruction,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic                done,
    output logic                illegal,
    input  logic [4:0]          dbg_addr,
    output logic [DataSize-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROR, ALU_MOV
    } alu_t;

    state_t state, state_nx;

    logic [31:0]         instr_q;
    logic [DataSize-1:0] regs [RegCount];
    logic [DataSize-1:0] opa_q, opb_q, result_q;
    logic [4:0]          rt_q;
    alu_t                alu_q;
    logic                ill_q;

    logic [5:0]  f_op;
    logic [4:0]  f_rt, f_ra, f_rb, f_sub;
    logic [14:0] f_imm15;
    logic [19:0] f_imm20;

    assign f_op    = instr_q[30:25];
    assign f_rt    = instr_q[24:20];
    assign f_ra    = instr_q[19:15];
    assign f_rb    = instr_q[14:10];
    assign f_sub   = instr_q[4:0];
    assign f_imm15 = instr_q[14:0];
    assign f_imm20 = instr_q[19:0];

    function automatic logic reg_ok(input logic [4:0] idx);
        return int'(idx) < RegCount;
    endfunction

    // Register reads via compare loops so any RegCount works with 5-bit indices;
    // out-of-range indices read as zero.
    logic [DataSize-1:0] rd_ra, rd_rb;
    always_comb begin
        rd_ra    = '0;
        rd_rb    = '0;
        dbg_data = '0;
        for (int i = 0; i < RegCount; i++) begin
            if (f_ra == i[4:0])     rd_ra    = regs[i];
            if (f_rb == i[4:0])     rd_rb    = regs[i];
            if (dbg_addr == i[4:0]) dbg_data = regs[i];
        end
    end

    alu_t                dec_alu;
    logic [DataSize-1:0] dec_b;
    logic                use_ra, use_rb, known, dec_ill;

    always_comb begin
        dec_alu = ALU_ADD;
        dec_b   = '0;
        use_ra  = 1'b0;
        use_rb  = 1'b0;
        known   = 1'b1;
        case (f_op)
            6'b101000: begin
                use_ra = 1'b1;
                dec_b  = {{(DataSize-15){f_imm15[14]}}, f_imm15};
            end
            6'b100010: begin
                dec_alu = ALU_MOV;
                dec_b   = {{(DataSize-20){f_imm20[19]}}, f_imm20};
            end
            6'b101100: begin
                dec_alu = ALU_OR;
                use_ra  = 1'b1;
                dec_b   = {{(DataSize-15){1'b0}}, f_imm15};
            end
            6'b101011: begin
                dec_alu = ALU_XOR;
                use_ra  = 1'b1;
                dec_b   = {{(DataSize-15){1'b0}}, f_imm15};
            end
            6'b100000: begin
                use_ra = 1'b1;
                use_rb = 1'b1;
                dec_b  = rd_rb;
                case (f_sub)
                    5'b00000: dec_alu = ALU_ADD;
                    5'b00001: dec_alu = ALU_SUB;
                    5'b00010: dec_alu = ALU_AND;
                    5'b00100: dec_alu = ALU_OR;
                    5'b00011: dec_alu = ALU_XOR;
                    5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
                        // shift forms reuse the rb field as imm5
                        use_rb = 1'b0;
                        dec_b  = {{(DataSize-5){1'b0}}, f_rb};
                        case (f_sub[1:0])
                            2'b00:   dec_alu = ALU_SLL;
                            2'b01:   dec_alu = ALU_SRL;
                            2'b10:   dec_alu = ALU_SRA;
                            default: dec_alu = ALU_ROR;
                        endcase
                    end
                    default: known = 1'b0;
                endcase
            end
            default: known = 1'b0;
        endcase
        dec_ill = instr_q[31] | ~known | ~reg_ok(f_rt)
                | (use_ra & ~reg_ok(f_ra)) | (use_rb & ~reg_ok(f_rb));
    end

    logic [4:0]            sh;
    logic [2*DataSize-1:0] rot;
    logic [DataSize-1:0]   alu_res;

    assign sh  = opb_q[4:0];
    assign rot = {opa_q, opa_q} >> sh;

    always_comb begin
        alu_res = '0;
        case (alu_q)
            ALU_ADD: alu_res = opa_q + opb_q;
            ALU_SUB: alu_res = opa_q - opb_q;
            ALU_AND: alu_res = opa_q & opb_q;
            ALU_OR:  alu_res = opa_q | opb_q;
            ALU_XOR: alu_res = opa_q ^ opb_q;
            ALU_SLL: alu_res = opa_q << sh;
            ALU_SRL: alu_res = opa_q >> sh;
            ALU_SRA: alu_res = $signed(opa_q) >>> sh;
            ALU_ROR: alu_res = rot[DataSize-1:0];
            ALU_MOV: alu_res = opb_q;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = DECODE;
            end
            DECODE:  state_nx = EXECUTE;
            EXECUTE: state_nx = WRITEBACK;
            WRITEBACK: begin
                done     = ~ill_q;
                illegal  = ill_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            rt_q     <= '0;
            alu_q    <= ALU_ADD;
            ill_q    <= 1'b0;
            for (int i = 0; i < RegCount; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: if (instr_valid) instr_q <= instruction;
                DECODE: begin
                    opa_q <= rd_ra;
                    opb_q <= dec_b;
                    alu_q <= dec_alu;
                    rt_q  <= f_rt;
                    ill_q <= dec_ill;
                end
                EXECUTE: result_q <= alu_res;
                WRITEBACK: begin
                    if (!ill_q) begin
                        for (int i = 0; i < RegCount; i++)
                            if (rt_q == i[4:0]) regs[i] <= result_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_core_p.sv
// tb_exec_core_p: drives one shared instruction stream into three instances
// (32x32, 32-bit with 8 registers, 64x32) and checks retire timing,
// done/illegal pulses and register contents against expected values.
module tb_exec_core_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [4:0]  dbg_addr;

    logic        rdy_a, done_a, ill_a;
    logic [31:0] dbg_a;
    logic        rdy_b, done_b, ill_b;
    logic [31:0] dbg_b;
    logic        rdy_c, done_c, ill_c;
    logic [63:0] dbg_c;

    exec_core_p #(.DataSize(32), .RegCount(32)) dut_a (
        .clk(clk), .reset(rst_n), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(rdy_a), .done(done_a), .illegal(ill_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a));
    exec_core_p #(.DataSize(32), .RegCount(8)) dut_b (
        .clk(clk), .reset(rst_n), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(rdy_b), .done(done_b), .illegal(ill_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b));
    exec_core_p #(.DataSize(64), .RegCount(32)) dut_c (
        .clk(clk), .reset(rst_n), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(rdy_c), .done(done_c), .illegal(ill_c), .dbg_addr(dbg_addr), .dbg_data(dbg_c));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [14:0] imm);
        return {1'b0, op, rt, ra, imm};
    endfunction
    function automatic logic [31:0] enc_m(input logic [4:0] rt, input logic [19:0] imm);
        return {1'b0, 6'b100010, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] sub, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [4:0] rb);
        return {1'b0, 6'b100000, rt, ra, rb, 5'b00000, sub};
    endfunction

    typedef struct {
        logic        ill;
        logic [4:0]  rt;
        logic [31:0] old_val;
        logic [31:0] new_val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  rt;
        logic [31:0] val;
        logic        hold;
    } vec_t;
    vec_t vt [24];

    logic [31:0] model [32];
    logic        seen_done_b, seen_ill_b;

    // Starts at a negedge with the cores in IDLE, returns at the negedge
    // after WRITEBACK (cores back in IDLE).
    task automatic run_instr(input logic [31:0] ins, input logic ill, input logic [4:0] rt,
                             input logic [31:0] val, input logic hold, input string name);
        exp_t e;
        int   n;
        logic sd, si;
        e.ill     = ill;
        e.rt      = rt;
        e.old_val = model[rt];
        e.new_val = ill ? model[rt] : val;
        sb.push_back(e);
        check({name, "_ready"}, {63'd0, rdy_a}, 64'd1);
        instruction = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        n = 1;
        if (hold) instruction = enc_m(5'd7, 20'h12345);
        else      instr_valid = 1'b0;
        while (!(done_a || ill_a) && n < 8) begin
            @(negedge clk);
            n++;
        end
        sd = done_a;
        si = ill_a;
        seen_done_b = done_b;
        seen_ill_b  = ill_b;
        instr_valid = 1'b0;
        e = sb.pop_front();
        check({name, "_latency"}, 64'(n), 64'd3);
        check({name, "_done"}, {63'd0, sd}, {63'd0, ~e.ill});
        check({name, "_illegal"}, {63'd0, si}, {63'd0, e.ill});
        dbg_addr = e.rt;
        #1;
        check({name, "_wb_old"}, {32'd0, dbg_a}, {32'd0, e.old_val});
        @(negedge clk);
        check({name, "_result"}, {32'd0, dbg_a}, {32'd0, e.new_val});
        model[e.rt] = e.new_val;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{enc_i(6'b101000, 5'd0, 5'd0, 15'd13),   1'b0, 5'd0,  32'd13,         1'b0};
        vt[1]  = '{enc_i(6'b101000, 5'd1, 5'd1, 15'd12),   1'b0, 5'd1,  32'd12,         1'b1};
        vt[2]  = '{enc_m(5'd2, 20'd16),                    1'b0, 5'd2,  32'd16,         1'b0};
        vt[3]  = '{enc_r(5'b00000, 5'd3, 5'd0, 5'd1),      1'b0, 5'd3,  32'd25,         1'b0};
        vt[4]  = '{enc_r(5'b00001, 5'd4, 5'd0, 5'd1),      1'b0, 5'd4,  32'd1,          1'b0};
        vt[5]  = '{enc_r(5'b00010, 5'd5, 5'd3, 5'd4),      1'b0, 5'd5,  32'd1,          1'b0};
        vt[6]  = '{enc_r(5'b00100, 5'd6, 5'd3, 5'd4),      1'b0, 5'd6,  32'd25,         1'b1};
        vt[7]  = '{enc_r(5'b00011, 5'd7, 5'd3, 5'd4),      1'b0, 5'd7,  32'd24,         1'b0};
        vt[8]  = '{enc_r(5'b01000, 5'd8, 5'd0, 5'd4),      1'b0, 5'd8,  32'h0000_00D0,  1'b0};
        vt[9]  = '{enc_r(5'b01011, 5'd9, 5'd1, 5'd8),      1'b0, 5'd9,  32'h0C00_0000,  1'b0};
        vt[10] = '{enc_i(6'b101100, 5'd0, 5'd0, 15'h1F),   1'b0, 5'd0,  32'h0000_001F,  1'b0};
        vt[11] = '{enc_i(6'b101011, 5'd1, 5'd1, 15'h15),   1'b0, 5'd1,  32'h0000_0019,  1'b0};
        vt[12] = '{enc_r(5'b00001, 5'd10, 5'd1, 5'd0),     1'b0, 5'd10, 32'hFFFF_FFFA,  1'b0};
        vt[13] = '{enc_r(5'b00000, 5'd6, 5'd6, 5'd6),      1'b0, 5'd6,  32'd50,         1'b0};
        vt[14] = '{enc_m(5'd2, 20'h80000),                 1'b0, 5'd2,  32'hFFF8_0000,  1'b0};
        vt[15] = '{enc_r(5'b01000, 5'd2, 5'd2, 5'd12),     1'b0, 5'd2,  32'h8000_0000,  1'b0};
        vt[16] = '{enc_r(5'b01010, 5'd3, 5'd2, 5'd4),      1'b0, 5'd3,  32'hF800_0000,  1'b0};
        vt[17] = '{enc_r(5'b01001, 5'd4, 5'd2, 5'd4),      1'b0, 5'd4,  32'h0800_0000,  1'b0};
        vt[18] = '{enc_i(6'b111111, 5'd3, 5'd0, 15'd0),    1'b1, 5'd3,  32'd0,          1'b0};
        vt[19] = '{enc_i(6'b101000, 5'd4, 5'd4, 15'd1) | 32'h8000_0000, 1'b1, 5'd4, 32'd0, 1'b1};
        vt[20] = '{enc_r(5'b00101, 5'd5, 5'd0, 5'd1),      1'b1, 5'd5,  32'd0,          1'b0};
        vt[21] = '{enc_i(6'b101000, 5'd11, 5'd10, 15'd6),  1'b0, 5'd11, 32'd0,          1'b0};
        vt[22] = '{enc_r(5'b01011, 5'd12, 5'd2, 5'd0),     1'b0, 5'd12, 32'h8000_0000,  1'b0};
        vt[23] = '{enc_r(5'b01010, 5'd13, 5'd3, 5'd31),    1'b0, 5'd13, 32'hFFFF_FFFF,  1'b0};

        for (int i = 0; i < 32; i++) model[i] = '0;
        seen_done_b = 1'b0;
        seen_ill_b  = 1'b0;
        rst_n       = 1'b0;
        instruction = '0;
        instr_valid = 1'b0;
        dbg_addr    = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, rdy_a}, 64'd1);
        check("rst_done", {63'd0, done_a}, 64'd0);
        check("rst_illegal", {63'd0, ill_a}, 64'd0);
        check("rst_r0", {32'd0, dbg_a}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++)
            run_instr(vt[i].ins, vt[i].ill, vt[i].rt, vt[i].val, vt[i].hold, $sformatf("v%0d", i));

        for (int r = 0; r < 16; r++) begin
            dbg_addr = 5'(r);
            #1;
            check($sformatf("sweep_r%0d", r), {32'd0, dbg_a}, {32'd0, model[r]});
        end

        // Reset while ADDI r5,r5,7 is in EXECUTE: aborted, registers cleared.
        instruction = enc_i(6'b101000, 5'd5, 5'd5, 15'd7);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n    = 1'b0;
        dbg_addr = 5'd5;
        #1;
        check("abort_ready", {63'd0, rdy_a}, 64'd1);
        check("abort_done", {63'd0, done_a}, 64'd0);
        check("abort_illegal", {63'd0, ill_a}, 64'd0);
        check("abort_r5", {32'd0, dbg_a}, 64'd0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk);
        @(negedge clk);
        check("abort_done_hold", {63'd0, done_a}, 64'd0);
        rst_n = 1'b1;

        // rt = 9 is legal with 32 registers but illegal with 8.
        run_instr(enc_i(6'b101000, 5'd9, 5'd0, 15'd1), 1'b0, 5'd9, 32'd1, 1'b0, "rc8");
        check("rc8_b_illegal", {63'd0, seen_ill_b}, 64'd1);
        check("rc8_b_done", {63'd0, seen_done_b}, 64'd0);
        check("rc8_b_r9_oob", {32'd0, dbg_b}, 64'd0);
        dbg_addr = 5'd1;
        #1;
        check("rc8_b_r1", {32'd0, dbg_b}, 64'd0);

        run_instr(enc_i(6'b101000, 5'd0, 5'd0, 15'h7FFF), 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, "w64_addi");
        dbg_addr = 5'd0;
        #1;
        check("w64_r0", dbg_c, 64'hFFFF_FFFF_FFFF_FFFF);
        run_instr(enc_r(5'b01011, 5'd1, 5'd0, 5'd8), 1'b0, 5'd1, 32'hFFFF_FFFF, 1'b0, "w64_rotri");
        dbg_addr = 5'd1;
        #1;
        check("w64_r1", dbg_c, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
